// File: rtl/fifo_arbiter.sv
// fifo_arbiter: round-robin mover from four source FIFOs to four destination
// FIFOs, routed by the top two bits of each word. It also owns the shared
// almost-full / almost-empty threshold registers, loaded and checked in INIT.
module fifo_arbiter #(
  parameter int WORD_SIZE = 6,
  parameter int PTR_L     = 5,
  parameter int MEM_SIZE  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   init,
  input  logic [PTR_L-1:0]       full_threshold_in,
  input  logic [PTR_L-1:0]       empty_threshold_in,
  output logic [PTR_L-1:0]       full_threshold,
  output logic [PTR_L-1:0]       empty_threshold,
  output logic                   cfg_error,
  input  logic [3:0]             in_empty,
  input  logic [4*WORD_SIZE-1:0] in_data,
  output logic [3:0]             in_rd,
  input  logic [3:0]             out_almost_full,
  output logic [3:0]             out_wr,
  output logic [WORD_SIZE-1:0]   out_data,
  output logic [1:0]             grant_idx,
  output logic [3:0]             state
);

  typedef enum logic [3:0] {
    ST_RESET  = 4'b0001,
    ST_INIT   = 4'b0010,
    ST_IDLE   = 4'b0100,
    ST_ACTIVE = 4'b1000
  } state_t;

  localparam logic [PTR_L-1:0] MEM_LIM = PTR_L'(MEM_SIZE);

  state_t                 state_q, state_d;
  logic [1:0]             ptr_q;
  logic [1:0]             grant_q;
  logic [3:0]             out_wr_q;
  logic [WORD_SIZE-1:0]   out_data_q;
  logic [PTR_L-1:0]       full_thr_q;
  logic [PTR_L-1:0]       empty_thr_q;
  logic                   cfg_err_q;

  logic [WORD_SIZE-1:0]   head [4];
  logic [3:0]             elig;
  logic                   any_elig;
  logic [1:0]             gnt;
  logic [1:0]             cand;
  logic                   found;
  logic                   pop;
  logic                   cfg_ok;

  function automatic logic [3:0] onehot2(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  function automatic logic [1:0] dest_of(input logic [WORD_SIZE-1:0] w);
    return w[WORD_SIZE-1 -: 2];
  endfunction

  // Split the packed heads and decide which sources can move this cycle.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      head[i] = in_data[i*WORD_SIZE +: WORD_SIZE];
      elig[i] = !in_empty[i] && !out_almost_full[dest_of(head[i])];
    end
  end

  assign any_elig = |elig;

  // Round-robin search starting just after the last granted source.
  always_comb begin
    gnt   = ptr_q;
    cand  = ptr_q;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!found && elig[cand]) begin
        gnt   = cand;
        found = 1'b1;
      end
    end
  end

  // Next-state logic; a pop happens only while staying in ACTIVE.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT:   if (!init) state_d = ST_IDLE;
      ST_IDLE: begin
        if (init)          state_d = ST_INIT;
        else if (any_elig) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (init)           state_d = ST_INIT;
        else if (!any_elig) state_d = ST_IDLE;
        else                pop     = 1'b1;
      end
      default:   state_d = ST_RESET;
    endcase
  end

  assign in_rd  = pop ? onehot2(gnt) : 4'b0000;
  assign cfg_ok = (empty_threshold_in < full_threshold_in) &&
                  (full_threshold_in <= MEM_LIM);

  // State, configuration and one-cycle push pipeline; reset discards in-flight words.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RESET;
      ptr_q       <= 2'd3;
      grant_q     <= 2'd3;
      out_wr_q    <= 4'b0000;
      out_data_q  <= '0;
      full_thr_q  <= '0;
      empty_thr_q <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_INIT) begin
        if (cfg_ok) begin
          full_thr_q  <= full_threshold_in;
          empty_thr_q <= empty_threshold_in;
          cfg_err_q   <= 1'b0;
        end else begin
          cfg_err_q   <= 1'b1;
        end
      end
      if (pop) begin
        ptr_q      <= gnt;
        grant_q    <= gnt;
        out_data_q <= head[gnt];
        out_wr_q   <= onehot2(dest_of(head[gnt]));
      end else begin
        out_wr_q   <= 4'b0000;
      end
    end
  end

  assign state           = state_q;
  assign out_wr          = out_wr_q;
  assign out_data        = out_data_q;
  assign grant_idx       = grant_q;
  assign full_threshold  = full_thr_q;
  assign empty_threshold = empty_thr_q;
  assign cfg_error       = cfg_err_q;

endmodule

// File: tb/tb_fifo_arbiter.sv
module tb_fifo_arbiter;

  localparam int W = 6;

  logic           clk = 1'b0;
  logic           reset;
  logic           init;
  logic [4:0]     full_threshold_in;
  logic [4:0]     empty_threshold_in;
  logic [4:0]     full_threshold;
  logic [4:0]     empty_threshold;
  logic           cfg_error;
  logic [3:0]     in_empty;
  logic [4*W-1:0] in_data;
  logic [3:0]     in_rd;
  logic [3:0]     out_almost_full;
  logic [3:0]     out_wr;
  logic [W-1:0]   out_data;
  logic [1:0]     grant_idx;
  logic [3:0]     state;

  int n_cmp  = 0;
  int n_fail = 0;

  fifo_arbiter #(.WORD_SIZE(W), .PTR_L(5), .MEM_SIZE(4)) dut (
    .clk(clk), .reset(reset), .init(init),
    .full_threshold_in(full_threshold_in), .empty_threshold_in(empty_threshold_in),
    .full_threshold(full_threshold), .empty_threshold(empty_threshold),
    .cfg_error(cfg_error), .in_empty(in_empty), .in_data(in_data), .in_rd(in_rd),
    .out_almost_full(out_almost_full), .out_wr(out_wr), .out_data(out_data),
    .grant_idx(grant_idx), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; registered outputs are then stable.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Apply inputs then let combinational outputs settle.
  task automatic settle();
    #1;
  endtask

  task automatic heads(input logic [W-1:0] s0, input logic [W-1:0] s1,
                       input logic [W-1:0] s2, input logic [W-1:0] s3);
    in_data = {s3, s2, s1, s0};
  endtask

  initial begin
    reset = 1'b1; init = 1'b0;
    full_threshold_in = 5'd0; empty_threshold_in = 5'd0;
    in_empty = 4'b1111; out_almost_full = 4'b0000;
    heads(6'd0, 6'd0, 6'd0, 6'd0);

    // Reset state
    tick(); tick(); settle();
    check("rst_state",  state, 4'b0001);
    check("rst_out_wr", out_wr, 4'b0000);
    check("rst_data",   out_data, 6'd0);
    check("rst_fthr",   full_threshold, 5'd0);
    check("rst_ethr",   empty_threshold, 5'd0);
    check("rst_cfgerr", cfg_error, 1'b0);
    check("rst_grant",  grant_idx, 2'd3);
    check("rst_in_rd",  in_rd, 4'b0000);

    // INIT with a valid pair
    reset = 1'b0; init = 1'b1; full_threshold_in = 5'd3; empty_threshold_in = 5'd1;
    tick(); settle();
    check("init_state", state, 4'b0010);
    check("init_in_rd", in_rd, 4'b0000);
    tick(); settle();
    check("init_fthr",   full_threshold, 5'd3);
    check("init_ethr",   empty_threshold, 5'd1);
    check("init_cfgerr", cfg_error, 1'b0);
    check("init_out_wr", out_wr, 4'b0000);

    // Invalid: empty >= full
    full_threshold_in = 5'd1; empty_threshold_in = 5'd2;
    tick(); settle();
    check("inv1_cfgerr", cfg_error, 1'b1);
    check("inv1_fthr",   full_threshold, 5'd3);
    check("inv1_ethr",   empty_threshold, 5'd1);
    // Valid boundary full == MEM_SIZE
    full_threshold_in = 5'd4; empty_threshold_in = 5'd0;
    tick(); settle();
    check("ok4_cfgerr", cfg_error, 1'b0);
    check("ok4_fthr",   full_threshold, 5'd4);
    check("ok4_ethr",   empty_threshold, 5'd0);
    // Invalid: full > MEM_SIZE
    full_threshold_in = 5'd5; empty_threshold_in = 5'd0;
    tick(); settle();
    check("inv5_cfgerr", cfg_error, 1'b1);
    check("inv5_fthr",   full_threshold, 5'd4);
    // Invalid: empty == full
    full_threshold_in = 5'd2; empty_threshold_in = 5'd2;
    tick(); settle();
    check("inveq_cfgerr", cfg_error, 1'b1);
    check("inveq_ethr",   empty_threshold, 5'd0);
    full_threshold_in = 5'd3; empty_threshold_in = 5'd1;
    tick(); settle();
    check("ok3_cfgerr", cfg_error, 1'b0);
    check("ok3_fthr",   full_threshold, 5'd3);

    // Round-robin over four ready sources
    init = 1'b0; in_empty = 4'b0000;
    heads(6'b00_0001, 6'b01_0010, 6'b10_0011, 6'b11_0100);
    tick(); settle();
    check("rr_idle_state", state, 4'b0100);
    check("rr_idle_in_rd", in_rd, 4'b0000);
    tick(); settle();
    check("rr_act_state", state, 4'b1000);
    check("rr_rd0", in_rd, 4'b0001);
    tick(); settle();
    check("rr_wr0",   out_wr, 4'b0001);
    check("rr_data0", out_data, 6'b00_0001);
    check("rr_gnt0",  grant_idx, 2'd0);
    check("rr_rd1",   in_rd, 4'b0010);
    tick(); settle();
    check("rr_wr1",   out_wr, 4'b0010);
    check("rr_data1", out_data, 6'b01_0010);
    check("rr_rd2",   in_rd, 4'b0100);
    tick(); settle();
    check("rr_wr2",   out_wr, 4'b0100);
    check("rr_data2", out_data, 6'b10_0011);
    check("rr_rd3",   in_rd, 4'b1000);
    tick(); settle();
    check("rr_wr3",   out_wr, 4'b1000);
    check("rr_data3", out_data, 6'b11_0100);
    check("rr_gnt3",  grant_idx, 2'd3);
    check("rr_rd4",   in_rd, 4'b0001);
    tick();
    check("rr_wr4",   out_wr, 4'b0001);

    // Source 0 blocked by almost-full destination 2; source 1 keeps moving
    in_empty = 4'b1100; out_almost_full = 4'b0100;
    heads(6'b10_0101, 6'b01_0010, 6'b10_0011, 6'b11_0100);
    settle();
    check("skip_rd_a", in_rd, 4'b0010);
    tick(); settle();
    check("skip_wr_a",   out_wr, 4'b0010);
    check("skip_data_a", out_data, 6'b01_0010);
    check("skip_gnt_a",  grant_idx, 2'd1);
    check("skip_rd_b",   in_rd, 4'b0010);
    tick();
    check("skip_wr_b", out_wr, 4'b0010);
    out_almost_full = 4'b0000;
    settle();
    check("unblk_rd", in_rd, 4'b0001);
    tick();
    check("unblk_wr",   out_wr, 4'b0100);
    check("unblk_data", out_data, 6'b10_0101);
    check("unblk_gnt",  grant_idx, 2'd0);

    // Single source with two words, then drain to IDLE
    in_empty = 4'b1011;
    heads(6'b10_0101, 6'b01_0010, 6'b11_0110, 6'b11_0100);
    settle();
    check("drain_rd1", in_rd, 4'b0100);
    tick();
    check("drain_wr1",   out_wr, 4'b1000);
    check("drain_data1", out_data, 6'b11_0110);
    heads(6'b10_0101, 6'b01_0010, 6'b01_0111, 6'b11_0100);
    settle();
    check("drain_rd2", in_rd, 4'b0100);
    tick();
    check("drain_wr2",    out_wr, 4'b0010);
    check("drain_data2",  out_data, 6'b01_0111);
    check("drain_state2", state, 4'b1000);
    in_empty = 4'b1111;
    settle();
    check("drain_rd_none", in_rd, 4'b0000);
    tick(); settle();
    check("drain_state", state, 4'b0100);
    check("drain_wr0",   out_wr, 4'b0000);
    check("drain_hold",  out_data, 6'b01_0111);
    tick(); settle();
    check("idle_stay", state, 4'b0100);

    // Reset in the cycle after a pop
    in_empty = 4'b1110;
    heads(6'b00_1000, 6'b01_0010, 6'b01_0111, 6'b11_0100);
    tick(); settle();
    check("mr_state", state, 4'b1000);
    check("mr_rd",    in_rd, 4'b0001);
    tick();
    check("mr_wr", out_wr, 4'b0001);
    reset = 1'b1;
    tick(); settle();
    check("mr_wr_rst",   out_wr, 4'b0000);
    check("mr_state_rst", state, 4'b0001);
    check("mr_data_rst", out_data, 6'd0);
    check("mr_gnt_rst",  grant_idx, 2'd3);
    check("mr_rd_rst",   in_rd, 4'b0000);
    reset = 1'b0;
    tick(); settle();
    check("mr_init", state, 4'b0010);
    check("mr_init_rd", in_rd, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_arbiter.md
Name: fifo_arbiter

Overview:
- Round-robin scheduler between four source FIFOs and four destination FIFOs in the interconnect device.
- Each source word carries a 2-bit destination field. The block pops one word per cycle from an eligible source and pushes it to the destination FIFO selected by that field.
- Sources whose destination is almost full are skipped.
- The block also owns the almost-full/almost-empty threshold configuration for all FIFOs. It latches the thresholds in an INIT state and validates them.

Parameters:
- WORD_SIZE, 6, word width in bits. Destination field is word[WORD_SIZE-1:WORD_SIZE-2].
- PTR_L, 5, width of the threshold buses.
- MEM_SIZE, 4, FIFO depth. Used for threshold validation.

Ports:
- clk  input  1  single clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- init  input  1  request to enter or stay in INIT and reload thresholds.
- full_threshold_in  input  PTR_L  requested almost_full threshold.
- empty_threshold_in  input  PTR_L  requested almost_empty threshold.
- full_threshold  output  PTR_L  registered threshold driven to all FIFOs.
- empty_threshold  output  PTR_L  registered threshold driven to all FIFOs.
- cfg_error  output  1  last INIT request carried an invalid threshold pair.
- in_empty  input  4  fifo_empty of sources 0..3.
- in_data  input  4*WORD_SIZE  show-ahead head word of each source; source i is bits [i*WORD_SIZE +: WORD_SIZE].
- in_rd  output  4  pop strobe, one-hot or zero, combinational.
- out_almost_full  input  4  almost_full of destinations 0..3.
- out_wr  output  4  push strobe, one-hot or zero, registered.
- out_data  output  WORD_SIZE  registered word to destinations.
- grant_idx  output  2  index of the last granted source.
- state  output  4  one-hot state: RESET=0001, INIT=0010, IDLE=0100, ACTIVE=1000.

Behaviour:
- **Reset.** reset=1 at a posedge sets:
  - state=RESET, out_wr=0, out_data=0
  - full_threshold=0, empty_threshold=0, cfg_error=0
  - round-robin pointer=3, so the first grant goes to source 0; grant_idx=3
  - in_rd=0 combinationally while state is RESET
  - Any in-flight word is discarded (out_wr not asserted). Reset has priority over everything, mid-transfer included.
- **Eligibility.** Source i is eligible when in_empty[i]=0 and out_almost_full[dest(in_data_i)]=0. A blocked source does not block other sources.
- **FSM transitions:**
  - RESET -> INIT unconditionally on the next edge.
  - INIT: in_rd=0. Each cycle, if empty_threshold_in < full_threshold_in and full_threshold_in <= MEM_SIZE, latch both thresholds and set cfg_error=0. Otherwise keep the old thresholds and set cfg_error=1. Stay while init=1; go to IDLE when init=0.
  - IDLE: in_rd=0. init=1 -> INIT. Any eligible source -> ACTIVE. Otherwise stay.
  - ACTIVE: init=1 -> INIT with no pop that cycle. No eligible source -> IDLE with no pop that cycle. Otherwise grant.
- **Grant (ACTIVE only).**
  - Search indices pointer+1, pointer+2, pointer+3, pointer+4 (mod 4) and take the first eligible index g.
  - Assert in_rd[g] in the same cycle.
  - On the edge: pointer<=g, grant_idx<=g, out_data<=in_data_g, out_wr<=one-hot(dest(in_data_g)).
- **Push timing and throughput.**
  - Pop-to-push latency is exactly 1 cycle. out_wr is high for exactly one cycle per popped word.
  - Sustained throughput is one word per cycle.
  - A word popped in the cycle the FSM leaves ACTIVE is still pushed on the following cycle (INIT/IDLE do not cancel it).
  - With no pop in a cycle, out_wr<=0 on the next edge and out_data holds its value.
- **Destination-full margin.** The destination almost_full margin must absorb the 1-word in-flight latency. Setting full_threshold <= MEM_SIZE-1 guarantees no overflow.
- **Single eligible source.** It is granted every cycle, with no forced idle cycle.
- **Widths.** Threshold comparisons are unsigned at PTR_L bits. Pointer arithmetic wraps mod 4.

Test Plan:
- **Reset/INIT.** reset=1 for 2 cycles, then init=1 with full_threshold_in=3, empty_threshold_in=1 -> state 0001 then 0010; full_threshold=3, empty_threshold=1, cfg_error=0; in_rd=0 and out_wr=0 throughout.
- **Invalid config.** In INIT, apply full_threshold_in=1, empty_threshold_in=2 -> cfg_error=1 and thresholds stay 3/1. Then apply 4/0 -> cfg_error=0 and thresholds become 4/0.
- **Round-robin.** All four sources non-empty, heads 6'b00_0001, 6'b01_0010, 6'b10_0011, 6'b11_0100, all out_almost_full=0 -> in_rd sequence 0001, 0010, 0100, 1000, 0001. Each next cycle: out_wr=0001, 0010, 0100, 1000 with matching out_data.
- **Skip blocked destination.** Sources 0 and 1 non-empty, source 0 head dest=2, out_almost_full=0100 -> only source 1 is popped. Deasserting out_almost_full[2] -> source 0 is granted at the next round-robin turn.
- **Drain to IDLE.** A single source holds 2 words -> in_rd asserted 2 consecutive cycles, then in_empty=1111 -> state IDLE, and the second out_wr occurs one cycle after the second pop.
- **Reset mid-transfer.** Assert reset in the cycle after a pop -> out_wr=0 at the next edge and state=0001.
